// File: rtl/seg_scan_ctrl_if.sv
// Load/acknowledge channel for seg_scan_ctrl: new display data in, one-cycle ack back.
interface seg_scan_ctrl_if #(
    parameter int NUM_DIGITS = 2
) ();
    logic                    load;
    logic [4*NUM_DIGITS-1:0] digit_data;
    logic                    load_ack;

    modport master (output load, output digit_data, input load_ack);
    modport slave  (input load, input digit_data, output load_ack);
endinterface

// File: rtl/seg_scan_ctrl.sv
// Time-multiplexed scan scheduler for a common-anode multi-digit 7-segment display.
// Define SEG_SCAN_BLANK_EN to insert an all-off blanking interval before each digit.
//
// state   | meaning
// --------+---------------------------------------------------------------
// S_IDLE  | scanning stopped, all digits off; loads go straight to active
// S_BLANK | all digits off, hex_out already presents the next digit
// S_ON    | digit idx powered for ON_CYCLES clocks
module seg_scan_ctrl #(
    parameter int NUM_DIGITS   = 2,
    parameter int ON_CYCLES    = 24000,
    parameter int BLANK_CYCLES = 480
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  enable,
    seg_scan_ctrl_if.slave        ld,
    output logic [3:0]            hex_out,
    output logic [NUM_DIGITS-1:0] digit_pow,
    output logic                  frame_done
);
    localparam int CNT_MAX = (ON_CYCLES > BLANK_CYCLES) ? ON_CYCLES : BLANK_CYCLES;
    localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
    localparam int IDX_W   = $clog2(NUM_DIGITS);
    localparam int DW      = 4 * NUM_DIGITS;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_BLANK = 2'd1;
    localparam logic [1:0] S_ON    = 2'd2;

`ifdef SEG_SCAN_BLANK_EN
    localparam logic [1:0] S_NEXT = S_BLANK;
`else
    localparam logic [1:0] S_NEXT = S_ON;
`endif

    localparam logic [CNT_W-1:0] ON_LAST    = CNT_W'(ON_CYCLES - 1);
    localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);
    localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(NUM_DIGITS - 1);

    logic [1:0]            state_q, state_d;
    logic [IDX_W-1:0]      idx_q, idx_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [DW-1:0]         active_q, active_d;
    logic [DW-1:0]         shadow_q, shadow_d;
    logic                  pend_q, pend_d;
    logic [3:0]            hex_q, hex_d;
    logic [NUM_DIGITS-1:0] digit_pow_q, digit_pow_d;
    logic                  frame_done_q, frame_done_d;
    logic                  load_ack_q, load_ack_d;
    logic                  boundary;
    logic                  advance;

    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        cnt_d        = cnt_q + CNT_W'(1);
        active_d     = active_q;
        shadow_d     = shadow_q;
        pend_d       = pend_q;
        hex_d        = hex_q;
        load_ack_d   = 1'b0;
        boundary     = 1'b0;
        advance      = 1'b0;

        if (!enable) begin
            state_d = S_IDLE;
            idx_d   = '0;
            cnt_d   = '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    state_d = S_NEXT;
                    idx_d   = '0;
                    cnt_d   = '0;
                    advance = 1'b1;
                end
                S_BLANK: begin
                    if (cnt_q == BLANK_LAST) begin
                        state_d = S_ON;
                        cnt_d   = '0;
                    end
                end
                S_ON: begin
                    if (cnt_q == ON_LAST) begin
                        state_d = S_NEXT;
                        cnt_d   = '0;
                        advance = 1'b1;
                        if (idx_q == IDX_LAST) begin
                            idx_d    = '0;
                            boundary = 1'b1;
                        end else begin
                            idx_d = idx_q + IDX_W'(1);
                        end
                    end
                end
                default: begin
                    state_d = S_IDLE;
                    idx_d   = '0;
                    cnt_d   = '0;
                end
            endcase
        end

        // A load coinciding with the boundary bypasses shadow so it is shown immediately.
        if (ld.load) begin
            if (state_q == S_IDLE || boundary) begin
                active_d   = ld.digit_data;
                pend_d     = 1'b0;
                load_ack_d = 1'b1;
            end else begin
                shadow_d = ld.digit_data;
                pend_d   = 1'b1;
            end
        end else if (boundary && pend_q) begin
            active_d   = shadow_q;
            pend_d     = 1'b0;
            load_ack_d = 1'b1;
        end

        frame_done_d = boundary;

        if (advance) begin
            hex_d = active_d[4*idx_d +: 4];
        end

        digit_pow_d = '1;
        if (state_d == S_ON) begin
            digit_pow_d[idx_d] = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= S_IDLE;
            idx_q        <= '0;
            cnt_q        <= '0;
            active_q     <= '0;
            shadow_q     <= '0;
            pend_q       <= 1'b0;
            hex_q        <= 4'h0;
            digit_pow_q  <= '1;
            frame_done_q <= 1'b0;
            load_ack_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            cnt_q        <= cnt_d;
            active_q     <= active_d;
            shadow_q     <= shadow_d;
            pend_q       <= pend_d;
            hex_q        <= hex_d;
            digit_pow_q  <= digit_pow_d;
            frame_done_q <= frame_done_d;
            load_ack_q   <= load_ack_d;
        end
    end

    assign hex_out     = hex_q;
    assign digit_pow   = digit_pow_q;
    assign frame_done  = frame_done_q;
    assign ld.load_ack = load_ack_q;

endmodule

// File: doc/seg_scan_ctrl.md
# seg_scan_ctrl

Time-multiplexing scheduler for the breadboarded common-anode multi-digit 7-segment display. It owns the single shared segment decoder path: it presents one hex nibble at a time on `hex_out` for the `seven_segment` decoder and drives the active-low per-digit power enables, with a blanking interval between digits to suppress ghosting. New display data is accepted through a load/ack handshake and applied only on frame boundaries, so a frame never shows mixed old and new digits.

## Interface
- `NUM_DIGITS`, 2: digits scanned, legal range 2..8.
- `ON_CYCLES`, 24000: clocks each digit is powered (500 us at 48 MHz); must be ≥1.
- `BLANK_CYCLES`, 480: clocks all digits are off before each digit turns on; must be ≥1.
- `clk` in 1: system clock, 48 MHz.
- `reset` in 1: asynchronous, active-low reset.
- `enable` in 1: scanning runs while high.
- `load` in 1: single-cycle request to replace display data.
- `digit_data` in 4*NUM_DIGITS: nibble i (bits 4i+3:4i) is digit i; sampled only in the cycle `load` is high.
- `load_ack` out 1: one-cycle pulse when the loaded data becomes active.
- `hex_out` out 4: nibble for the currently selected digit.
- `digit_pow` out NUM_DIGITS: active-low digit power; 0 means powered; at most one bit is 0.
- `frame_done` out 1: one-cycle pulse at the end of each complete scan frame.

## Operation
- Registers: `active` (displayed data), `shadow` (pending data), `pend` flag, digit index `idx`, cycle counter of width $clog2(max(ON_CYCLES, BLANK_CYCLES)).
- States: IDLE, BLANK, ON.
- IDLE: `digit_pow` all ones. When `enable`=1: go to BLANK, `idx`←0, `hex_out`←active[0], counter←0.
- BLANK: `digit_pow` all ones. After BLANK_CYCLES clocks, go to ON, counter←0.
- ON: `digit_pow[idx]`=0. After ON_CYCLES clocks, go to BLANK with `idx`←idx+1. When `idx`=NUM_DIGITS-1, `idx` wraps to 0 and this is the frame boundary.
- `hex_out` changes only on the transition into BLANK, or into ON when blanking is compiled out. It never changes while any digit is powered.
- Frame boundary actions:
  - `frame_done`=1 for one cycle.
  - If `pend`: `active`←shadow, `pend`←0, `load_ack`=1.
  - `hex_out` takes digit 0 of the new `active`.
- `load` while scanning: `shadow`←digit_data, `pend`←1. A second load before the boundary overwrites `shadow` and produces only one ack.
- `load` in the same cycle as the boundary: `digit_data` goes directly to `active`, `pend`←0, and `load_ack` pulses at that boundary.
- `load` in IDLE: `active`←digit_data on the next edge, `load_ack` pulses in that cycle, and `pend` stays 0.
- `enable` falling in any state: next edge goes to IDLE, `digit_pow` all ones, `idx`←0, counter←0. `pend` and `shadow` are kept; pending data applies on the next load in IDLE or at the next frame boundary.
- Reset (any time, asynchronous):
  - state IDLE, `digit_pow` all ones, `hex_out`=0, `active`=`shadow`=0, `pend`=0, `idx`=0.
  - `load_ack`=0, `frame_done`=0.

## Timing
- All outputs are registered; none is a combinational function of an input.
- With `enable` sampled high at edge 0 in IDLE:
  - `digit_pow[0]` goes low at edge BLANK_CYCLES.
  - `digit_pow[0]` goes high at edge BLANK_CYCLES+ON_CYCLES.
- Digit period is BLANK_CYCLES+ON_CYCLES clocks; frame period is NUM_DIGITS times the digit period.
- `frame_done` and `load_ack` assert on the same edge that returns to BLANK with `idx`=0, and last exactly one cycle.
- Load-to-display latency is at most one frame plus one clock.

## Configuration
- `SEG_SCAN_BLANK_EN` defined: BLANK state present as described above.
- `SEG_SCAN_BLANK_EN` undefined:
  - BLANK state and BLANK_CYCLES are not used.
  - IDLE goes directly to ON.
  - ON goes directly to ON of the next digit; `digit_pow` and `hex_out` switch on the same edge.
  - Digit period is ON_CYCLES.
  - All other behaviour is unchanged.

## Test plan
Use NUM_DIGITS=2, ON_CYCLES=8, BLANK_CYCLES=2 unless noted.
- Reset with `reset`=0 while `enable`=1 mid-ON → `digit_pow`=2'b11 and `hex_out`=0 immediately, with no clock edge needed; after release, scanning restarts from digit 0 with `active`=0.
- Load 8'h3A in IDLE, then `enable`=1 at edge 0:
  - `load_ack` pulses one cycle after the load.
  - `hex_out`=4'hA during edges 0–10; `digit_pow`=2'b10 from edge 2 to 10.
  - `hex_out`=4'h3 from edge 10; `digit_pow`=2'b01 from edge 12 to 20.
  - `frame_done` pulses at edge 20.
- While scanning, load 8'h55 then 8'h71 in the same frame → exactly one `load_ack`, at the frame boundary; the next frame shows 1 then 7; no frame mixes 5 with 1/7.
- `load` of 8'h9C asserted exactly on the frame-boundary cycle → `load_ack` at that boundary and `hex_out`=4'hC on the same edge.
- Drop `enable` mid-ON of digit 1 → `digit_pow`=2'b11 on the next edge; a pending load is retained and acked at the first boundary after re-enable.
- NUM_DIGITS=4 with `SEG_SCAN_BLANK_EN` undefined → each digit is on 8 cycles back-to-back, `frame_done` fires every 32 cycles, and `digit_pow` never has two zero bits.
